// File: rtl/cond_exec_pkg.sv
// Shared types for the D->E conditional-execution stage.
// Condition codes, NZCV flag layout and the E-register control bundle.
// Pure type/constant package; no logic.
package cond_exec_pkg;

  // ARM condition field encodings
  typedef enum logic [3:0] {
    COND_EQ = 4'h0,
    COND_NE = 4'h1,
    COND_CS = 4'h2,
    COND_CC = 4'h3,
    COND_MI = 4'h4,
    COND_PL = 4'h5,
    COND_VS = 4'h6,
    COND_VC = 4'h7,
    COND_HI = 4'h8,
    COND_LS = 4'h9,
    COND_GE = 4'hA,
    COND_LT = 4'hB,
    COND_GT = 4'hC,
    COND_LE = 4'hD,
    COND_AL = 4'hE,
    COND_NV = 4'hF
  } cond_e;

  // Architectural flags, MSB first: {N,Z,C,V}
  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } flags_t;

  // Single-bit controls held in the E register (ALU op kept separately,
  // its width is a top-level parameter)
  typedef struct packed {
    logic       pcs;
    logic       regw;
    logic       memw;
    logic       nowrite;
    logic       memtoreg;
    logic       alusrc;
    logic [1:0] flagw;
    cond_e      cond;
  } ctrl_e_t;

  // Bit positions inside FlagW
  localparam int FLAGW_NZ = 1;
  localparam int FLAGW_CV = 0;

endpackage

// File: rtl/cond_exec_stage_cond_check.sv
// Condition evaluator: cond field vs NZCV -> pass/fail.
// Latency: 0 cycles (purely combinational).
// Backpressure: none; stateless.
module cond_check
  import cond_exec_pkg::*;
(
  input  cond_e  i_cond,
  input  flags_t i_flags,
  output logic   o_cond_ex
);

  // Decode the condition against the current flags
  always_comb begin
    o_cond_ex = 1'b1;
    case (i_cond)
      COND_EQ: o_cond_ex = i_flags.z;
      COND_NE: o_cond_ex = ~i_flags.z;
      COND_CS: o_cond_ex = i_flags.c;
      COND_CC: o_cond_ex = ~i_flags.c;
      COND_MI: o_cond_ex = i_flags.n;
      COND_PL: o_cond_ex = ~i_flags.n;
      COND_VS: o_cond_ex = i_flags.v;
      COND_VC: o_cond_ex = ~i_flags.v;
      COND_HI: o_cond_ex = i_flags.c & ~i_flags.z;
      COND_LS: o_cond_ex = ~i_flags.c | i_flags.z;
      COND_GE: o_cond_ex = (i_flags.n == i_flags.v);
      COND_LT: o_cond_ex = (i_flags.n != i_flags.v);
      COND_GT: o_cond_ex = ~i_flags.z & (i_flags.n == i_flags.v);
      COND_LE: o_cond_ex = i_flags.z | (i_flags.n != i_flags.v);
      default: o_cond_ex = 1'b1;  // AL and 1111 both execute unconditionally
    endcase
  end

endmodule

// File: rtl/cond_exec_stage.sv
// D->E pipeline register with conditional gating of PC/reg/mem/flag writes.
// Latency: 1 cycle D->E capture; gated outputs and CondExE are 0-cycle from E state.
// Backpressure: StallE holds E and blocks flag update; FlushE (wins) inserts a bubble.
module cond_exec_stage
  import cond_exec_pkg::*;
#(
  parameter int         ALU_CTRL_W = 3,
  parameter logic [3:0] FLAGS_RST  = 4'b0000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  StallE,
  input  logic                  FlushE,
  input  logic                  PCSD,
  input  logic                  RegWD,
  input  logic                  MemWD,
  input  logic                  NoWriteD,
  input  logic                  MemtoRegD,
  input  logic                  ALUSrcD,
  input  logic [ALU_CTRL_W-1:0] ALUControlD,
  input  logic [1:0]            FlagWD,
  input  logic [3:0]            CondD,
  input  logic [3:0]            ALUFlags,
  output logic                  PCSrcE,
  output logic                  RegWriteE,
  output logic                  MemWriteE,
  output logic                  MemtoRegE,
  output logic                  ALUSrcE,
  output logic [ALU_CTRL_W-1:0] ALUControlE,
  output logic                  CondExE,
  output logic                  ValidE,
  output logic [3:0]            FlagsQ
);

  ctrl_e_t               r_ctrl;
  logic [ALU_CTRL_W-1:0] r_alu_ctrl;
  logic                  r_valid;
  flags_t                r_flags;

  ctrl_e_t               w_ctrl_d;
  flags_t                w_alu_flags;
  logic                  w_cond_ex;
  logic                  w_exec;
  logic                  w_flag_we;

  // Bundle decoder outputs into the E-register layout
  always_comb begin
    w_ctrl_d          = '0;
    w_ctrl_d.pcs      = PCSD;
    w_ctrl_d.regw     = RegWD;
    w_ctrl_d.memw     = MemWD;
    w_ctrl_d.nowrite  = NoWriteD;
    w_ctrl_d.memtoreg = MemtoRegD;
    w_ctrl_d.alusrc   = ALUSrcD;
    w_ctrl_d.flagw    = FlagWD;
    w_ctrl_d.cond     = cond_e'(CondD);
  end

  assign w_alu_flags = flags_t'(ALUFlags);

  // E register: flush beats stall beats load
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ctrl     <= '0;
      r_alu_ctrl <= '0;
      r_valid    <= 1'b0;
    end else if (FlushE) begin
      r_ctrl     <= '0;
      r_alu_ctrl <= '0;
      r_valid    <= 1'b0;
    end else if (!StallE) begin
      r_ctrl     <= w_ctrl_d;
      r_alu_ctrl <= ALUControlD;
      r_valid    <= 1'b1;
    end
  end

  cond_check u_cond_check (
    .i_cond    (r_ctrl.cond),
    .i_flags   (r_flags),
    .o_cond_ex (w_cond_ex)
  );

  // An instruction only has side effects if it is real and its condition holds
  assign w_exec = r_valid & w_cond_ex;

  // Flags commit only on the edge where the instruction leaves E normally,
  // so a stalled instruction writes once and a flushed one never does
  assign w_flag_we = w_exec & ~StallE & ~FlushE;

  // NZCV register with independent N/Z and C/V write lanes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_flags <= flags_t'(FLAGS_RST);
    end else if (w_flag_we) begin
      if (r_ctrl.flagw[FLAGW_NZ]) begin
        r_flags.n <= w_alu_flags.n;
        r_flags.z <= w_alu_flags.z;
      end
      if (r_ctrl.flagw[FLAGW_CV]) begin
        r_flags.c <= w_alu_flags.c;
        r_flags.v <= w_alu_flags.v;
      end
    end
  end

  assign PCSrcE      = r_ctrl.pcs & w_exec;
  assign RegWriteE   = r_ctrl.regw & ~r_ctrl.nowrite & w_exec;
  assign MemWriteE   = r_ctrl.memw & w_exec;
  assign MemtoRegE   = r_ctrl.memtoreg;
  assign ALUSrcE     = r_ctrl.alusrc;
  assign ALUControlE = r_alu_ctrl;
  assign CondExE     = w_cond_ex;
  assign ValidE      = r_valid;
  assign FlagsQ      = r_flags;

endmodule
